tdm_demux_4: RTL and testbench

TDM_DEMUX_4 -- requirements
Module: tdm_demux_4

---
 rtl/tdm_demux_4.sv | 123 ++++++++++++
 tb/tb_tdm_demux_4.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux_4.sv
// TDM demux: splits a 4-slot frame on din into registered channels m0..m3; commit visible the cycle after the last beat.
// Optional even-parity trailer beat when TDM_DEMUX_PARITY_EN is defined; din_valid low simply stalls all state.
module tdm_demux_4 #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  input  logic         din_valid,
  input  logic         frame_start,
  output logic [W-1:0] m0,
  output logic [W-1:0] m1,
  output logic [W-1:0] m2,
  output logic [W-1:0] m3,
  output logic         frame_valid,
  output logic         sync_err,
  output logic         par_err,
  output logic         busy
);

`ifdef TDM_DEMUX_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAR = 2'd2} state_e;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1} state_e;
`endif

  state_e              state_q, state_d;
  logic [1:0]          slot_q, slot_d;
  logic [3:0][W-1:0]   shadow_q, shadow_d;
  logic [3:0][W-1:0]   m_q, m_d;
  logic                frame_valid_q, frame_valid_d;
  logic                sync_err_q, sync_err_d;
`ifdef TDM_DEMUX_PARITY_EN
  logic                par_err_q, par_err_d;
`endif

  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    shadow_d      = shadow_q;
    m_d           = m_q;
    frame_valid_d = 1'b0;
    sync_err_d    = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
    par_err_d     = 1'b0;
`endif
    if (din_valid) begin
      // A frame_start beat always resynchronises, whatever the state.
      if (frame_start) begin
        sync_err_d  = (state_q != IDLE);
        shadow_d[0] = din;
        slot_d      = 2'd1;
        state_d     = RUN;
      end else begin
        case (state_q)
          RUN: begin
            shadow_d[slot_q] = din;
            slot_d           = slot_q + 2'd1;
            if (slot_q == 2'd3) begin
`ifdef TDM_DEMUX_PARITY_EN
              state_d = PAR;
`else
              m_d           = {din, shadow_q[2], shadow_q[1], shadow_q[0]};
              frame_valid_d = 1'b1;
              state_d       = IDLE;
`endif
            end
          end
`ifdef TDM_DEMUX_PARITY_EN
          PAR: begin
            if (din[0] == (^shadow_q)) begin
              m_d           = shadow_q;
              frame_valid_d = 1'b1;
            end else begin
              par_err_d = 1'b1;
            end
            state_d = IDLE;
          end
`endif
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      slot_q        <= 2'd0;
      shadow_q      <= '0;
      m_q           <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      par_err_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      shadow_q      <= shadow_d;
      m_q           <= m_d;
      frame_valid_q <= frame_valid_d;
      sync_err_q    <= sync_err_d;
`ifdef TDM_DEMUX_PARITY_EN
      par_err_q     <= par_err_d;
`endif
    end
  end

  assign m0          = m_q[0];
  assign m1          = m_q[1];
  assign m2          = m_q[2];
  assign m3          = m_q[3];
  assign frame_valid = frame_valid_q;
  assign sync_err    = sync_err_q;
  assign busy        = (state_q != IDLE);
`ifdef TDM_DEMUX_PARITY_EN
  assign par_err     = par_err_q;
`else
  assign par_err     = 1'b0;
`endif

endmodule

// File: tb/tb_tdm_demux_4.sv
// Bench for tdm_demux_4: frame-level reference model plus directed literal checks.
module tb_tdm_demux_4;
  localparam int W = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         din_valid = 1'b0;
  logic         frame_start = 1'b0;
  logic [W-1:0] din = '0;
  logic [W-1:0] m0, m1, m2, m3;
  logic         frame_valid, sync_err, par_err, busy;

  tdm_demux_4 #(.W(W)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .frame_start(frame_start),
    .m0(m0), .m1(m1), .m2(m2), .m3(m3),
    .frame_valid(frame_valid), .sync_err(sync_err), .par_err(par_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  bit check_en = 1'b0;

  // Model: beats gathered since the last frame_start, and what the outputs must show after each edge.
  bit           inframe = 1'b0;
  logic [W-1:0] got[$];
  logic [W-1:0] exp_m[4];
  logic         exp_fv = 1'b0, exp_se = 1'b0, exp_pe = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
  endtask

  function automatic logic par4(input logic [W-1:0] a, b, c, d);
    return ^{a, b, c, d};
  endfunction

  task automatic model_reset();
    inframe = 1'b0;
    got.delete();
    for (int i = 0; i < 4; i++) exp_m[i] = '0;
    exp_fv = 1'b0; exp_se = 1'b0; exp_pe = 1'b0;
  endtask

  task automatic model_commit();
    for (int i = 0; i < 4; i++) exp_m[i] = got[i];
    exp_fv = 1'b1;
  endtask

  task automatic model_step(input logic v, input logic fs, input logic [W-1:0] d);
    exp_fv = 1'b0; exp_se = 1'b0; exp_pe = 1'b0;
    if (v) begin
      if (fs) begin
        exp_se = inframe;
        inframe = 1'b1;
        got.delete();
        got.push_back(d);
      end else if (inframe) begin
        got.push_back(d);
`ifdef TDM_DEMUX_PARITY_EN
        if (got.size() == 5) begin
          if (got[4][0] == par4(got[0], got[1], got[2], got[3])) model_commit();
          else exp_pe = 1'b1;
          inframe = 1'b0;
        end
`else
        if (got.size() == 4) begin
          model_commit();
          inframe = 1'b0;
        end
`endif
      end
    end
  endtask

  // Single compare process: every cycle, just after the rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (check_en) begin
        chk("m0", 32'(m0), 32'(exp_m[0]));
        chk("m1", 32'(m1), 32'(exp_m[1]));
        chk("m2", 32'(m2), 32'(exp_m[2]));
        chk("m3", 32'(m3), 32'(exp_m[3]));
        chk("frame_valid", 32'(frame_valid), 32'(exp_fv));
        chk("sync_err", 32'(sync_err), 32'(exp_se));
        chk("par_err", 32'(par_err), 32'(exp_pe));
        chk("busy", 32'(busy), 32'(inframe));
      end
    end
  end

  task automatic beat(input logic fs, input logic [W-1:0] d);
    @(negedge clk);
    din_valid = 1'b1; frame_start = fs; din = d;
    model_step(1'b1, fs, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      din_valid = 1'b0; frame_start = 1'b0; din = W'($urandom);
      model_step(1'b0, 1'b0, din);
    end
  endtask

  task automatic par_beat(input logic [W-1:0] a, b, c, d);
`ifdef TDM_DEMUX_PARITY_EN
    logic [W-1:0] pb;
    pb = W'($urandom);
    pb[0] = par4(a, b, c, d);
    beat(1'b0, pb);
`else
    if (a === 'x && b === 'x && c === 'x && d === 'x) $display("par_beat: unknown data");
`endif
  endtask

  task automatic frame4(input logic [W-1:0] a, b, c, d);
    beat(1'b1, a); beat(1'b0, b); beat(1'b0, c); beat(1'b0, d);
    par_beat(a, b, c, d);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_m(input string tag, input logic [W-1:0] a, b, c, d);
    chk({tag, "_m0"}, 32'(m0), 32'(a));
    chk({tag, "_m1"}, 32'(m1), 32'(b));
    chk({tag, "_m2"}, 32'(m2), 32'(c));
    chk({tag, "_m3"}, 32'(m3), 32'(d));
  endtask

  initial begin
    model_reset();
    #1 rst = 1'b1;
    #2;
    chk_m("reset", 0, 0, 0, 0);
    chk("reset_fv", 32'(frame_valid), 0);
    chk("reset_se", 32'(sync_err), 0);
    chk("reset_pe", 32'(par_err), 0);
    chk("reset_busy", 32'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    model_step(1'b0, 1'b0, '0);
    check_en = 1'b1;

    // Beat without frame_start in IDLE is dropped.
    beat(1'b0, 2'd3);
    after_edge();
    chk("discard_busy", 32'(busy), 0);

    // Basic frame.
    frame4(2'd1, 2'd2, 2'd3, 2'd0);
    after_edge();
    chk("basic_fv", 32'(frame_valid), 1);
    chk_m("basic", 2'd1, 2'd2, 2'd3, 2'd0);
    idle(1);
    after_edge();
    chk("basic_fv_drop", 32'(frame_valid), 0);

    // Stall of 3 cycles mid-frame.
    beat(1'b1, 2'd1); beat(1'b0, 2'd2);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      after_edge();
      chk("gap_busy", 32'(busy), 1);
      chk("gap_fv", 32'(frame_valid), 0);
    end
    beat(1'b0, 2'd3); beat(1'b0, 2'd0);
    par_beat(2'd1, 2'd2, 2'd3, 2'd0);
    after_edge();
    chk("gap_fv_commit", 32'(frame_valid), 1);
    chk_m("gap", 2'd1, 2'd2, 2'd3, 2'd0);

    // Early frame_start, immediately following the previous commit.
    beat(1'b1, 2'd3); beat(1'b0, 2'd1); beat(1'b1, 2'd2);
    after_edge();
    chk("resync_se", 32'(sync_err), 1);
    chk("resync_fv", 32'(frame_valid), 0);
    chk_m("resync_hold", 2'd1, 2'd2, 2'd3, 2'd0);
    beat(1'b0, 2'd0); beat(1'b0, 2'd1); beat(1'b0, 2'd3);
    par_beat(2'd2, 2'd0, 2'd1, 2'd3);
    after_edge();
    chk("resync_fv_commit", 32'(frame_valid), 1);
    chk_m("resync", 2'd2, 2'd0, 2'd1, 2'd3);

`ifdef TDM_DEMUX_PARITY_EN
    // Wrong parity: 3,3,3,3 has even bit count, so parity bit 1 is a mismatch.
    beat(1'b1, 2'd3); beat(1'b0, 2'd3); beat(1'b0, 2'd3); beat(1'b0, 2'd3);
    beat(1'b0, 2'b11);
    after_edge();
    chk("parity_pe", 32'(par_err), 1);
    chk("parity_fv", 32'(frame_valid), 0);
    chk_m("parity_hold", 2'd2, 2'd0, 2'd1, 2'd3);
`endif

    // Asynchronous reset mid-frame.
    idle(1);
    beat(1'b1, 2'd2); beat(1'b0, 2'd1);
    @(posedge clk);
    #3;
    rst = 1'b1; din_valid = 1'b0; frame_start = 1'b0;
    model_reset();
    #1;
    chk_m("arst", 0, 0, 0, 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_fv", 32'(frame_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    model_step(1'b0, 1'b0, '0);
    beat(1'b0, 2'd3);
    frame4(2'd3, 2'd1, 2'd0, 2'd2);
    after_edge();
    chk("post_rst_fv", 32'(frame_valid), 1);
    chk_m("post_rst", 2'd3, 2'd1, 2'd0, 2'd2);
    idle(2);

    check_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish, got %0d/%0d", n_pass, n_total);
    $fatal(1, "timeout");
  end
endmodule
